seg_scan_arbiter: RTL and testbench
===================================

Name: seg_scan_arbiter

Overview:
Scan controller and arbiter for the board's shared 4-digit multiplexed 7-segment display. It time-slices the display across digits, with a blanking gap between slots to prevent ghosting. It shares the display between two requesters: A is the BCD counter (default owner) and B is an override/message source with priority. Switching between owners happens only on frame boundaries.

Parameters:
SCAN_DIV, 2000, clk cycles per digit slot (must be at least BLANK_CYCLES+2)
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
dig_a  in  16  requester A BCD digits: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands
dig_b  in  16  requester B digits, same packing
req_b  in  1  B requests the display (level)
lz_en  in  1  leading-zero suppression enable
gnt_b  out  1  B currently owns the display
ctrl  out  4  digit enables, active-low one-hot: units 4'b0111, tens 4'b1011, hundreds 4'b1101, thousands 4'b1110, all off 4'b1111
segment  out  8  active-high segments: bit7=a … bit1=g, bit0=dp
frame_done  out  1  one-cycle pulse when the thousands slot ends

Behaviour:
- Reset, one clock only. Synchronous and active-high as fixed above.
  - Outputs: ctrl=4'b1111, segment=8'h00, gnt_b=0, frame_done=0.
  - Internal: prescaler=0, digit index=0, state=BLANK, owner=A, snapshot=16'h0000.
  - Asserting reset mid-slot or mid-frame aborts the slot/frame immediately; the first slot after reset is units.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The slot tick is prescaler==SCAN_DIV-1.
- Slot state machine, 2 states:
  - BLANK: ctrl=1111, segment=00. Moves to SHOW when prescaler==BLANK_CYCLES-1.
  - SHOW: ctrl = enable for the current index; segment = decoded digit. Moves to BLANK on the slot tick.
- Digit index advances 0→1→2→3→0 on each slot tick. frame_done pulses in the cycle after the tick that wraps 3→0.
- Frame boundary is the slot tick at index 3. In that same cycle:
  - Owner is re-arbitrated: B if req_b=1, else A. B has fixed priority; there is no fairness requirement.
  - The snapshot register loads the new owner's dig_x, so every frame displays a coherent value with no tearing.
  - Out-of-reset case: the first frame shows snapshot 0000 from A; arbitration first takes effect at the end of that frame.
- gnt_b is registered and equals (owner==B). It changes only at frame boundaries.
  - If req_b falls mid-frame, B keeps the display until the frame ends.
  - If req_b rises mid-frame, the grant waits for the boundary. Worst-case grant latency is 4·SCAN_DIV cycles.
- Decode (units digit always displayed, never suppressed):
  - Codes 0-9 use the standard patterns, e.g. 0=FC, 1=60, 8=FE, 9=F6.
  - Codes 10-15 show a dash (segment=8'h02).
  - dp is always 0.
- Leading-zero suppression, lz_en=1 only: a thousands, hundreds or tens digit shows segment=00 (ctrl still asserted) when it and every higher digit are zero. An invalid code (10-15) counts as non-zero.
- lz_en is sampled every cycle; a change affects the current SHOW output on the next cycle.
- All outputs are registered: ctrl and segment update one clk after the state/index change that causes them.

Decomposition:
- Package seg_pkg holds:
  - constants SEG_BLANK=8'h00, SEG_DASH=8'h02, CTRL_OFF=4'b1111;
  - the per-index ctrl one-hot table;
  - the digit-pattern table;
  - the owner enum {OWN_A, OWN_B} and the slot-state enum {ST_BLANK, ST_SHOW}.
- One natural sub-module: seg_decoder, combinational, taking a 4-bit code and a blank flag and producing the 8-bit segment value. The counter and later display blocks reuse it.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset, then dig_a=16'h1234, no req_b.
   - First frame shows 0000 (snapshot cleared).
   - Second frame: ctrl sequence 0111, 1011, 1101, 1110 with segment 66, F2, DA, 60 (digits 4, 3, 2, 1).
   - Each slot shows 2 cycles of 1111/00, then 6 cycles lit; frame_done pulses every 32 cycles.
2. Raise req_b at mid-hundreds slot with dig_b=16'h0009.
   - gnt_b stays 0 until the thousands slot tick, then goes 1.
   - The next frame shows F6, FC, FC, FC.
3. Drop req_b during B's tens slot → B holds until the frame ends; gnt_b falls at the boundary and A's value appears.
4. lz_en=1 with dig_a=16'h0050.
   - Thousands and hundreds slots: segment=00, ctrl still enabled. Tens=B6, units=FC.
   - With dig_a=16'h0000, only units shows FC.
5. dig_a=16'hA00C → units and thousands show 02; with lz_en=1 the hundreds and tens zeros still display FC, because thousands is non-zero.
6. Assert reset during a SHOW slot of index 2 → the next cycle has ctrl=1111, segment=00, gnt_b=0; after release the scan restarts at units following 2 blank cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, tables and enums for the 7-segment display blocks
//
// Contents:
//   SEG_BLANK, SEG_DASH, CTRL_OFF  fixed output codes
//   CTRL_TAB                       active-low digit enable per scan index (0=units .. 3=thousands)
//   DIGIT_PAT                      active-high segment patterns for codes 0-9 (bit7=a .. bit1=g, bit0=dp)
//   owner_e, slot_state_e          display owner and scan slot state
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [3:0] CTRL_OFF  = 4'b1111;

  // Indexed by scan index: [0]=units .. [3]=thousands.
  localparam logic [3:0][3:0] CTRL_TAB = {
    4'b1110,  // thousands
    4'b1101,  // hundreds
    4'b1011,  // tens
    4'b0111   // units
  };

  // Indexed by digit code 0..9; dp (bit0) is always clear.
  localparam logic [9:0][7:0] DIGIT_PAT = {
    8'hF6,  // 9
    8'hFE,  // 8
    8'hE0,  // 7
    8'hBE,  // 6
    8'hB6,  // 5
    8'h66,  // 4
    8'hF2,  // 3
    8'hDA,  // 2
    8'h60,  // 1
    8'hFC   // 0
  };

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } slot_state_e;

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational digit code to 7-segment pattern decoder
//
// Ports:
//   code     in  4  digit code; 0-9 decode normally, 10-15 show a dash
//   blank    in  1  force all segments off
//   segment  out 8  active-high segments, bit7=a .. bit1=g, bit0=dp (always 0)
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [7:0] segment
);

  always_comb begin
    segment = SEG_BLANK;
    if (!blank) begin
      if (code <= 4'd9) begin
        segment = DIGIT_PAT[code];
      end else begin
        segment = SEG_DASH;
      end
    end
  end

endmodule

// File: rtl/seg_scan_arbiter.sv
// rtl/seg_scan_arbiter.sv - 4-digit multiplexed display scanner with frame-boundary A/B arbitration
//
// Ports:
//   clk         in  1   system clock
//   reset       in  1   synchronous, active-high reset
//   dig_a       in  16  requester A digits: [3:0] units .. [15:12] thousands
//   dig_b       in  16  requester B digits, same packing
//   req_b       in  1   B requests the display (level)
//   lz_en       in  1   leading-zero suppression enable
//   gnt_b       out 1   B currently owns the display
//   ctrl        out 4   active-low one-hot digit enables, 4'b1111 = all off
//   segment     out 8   active-high segments, bit7=a .. bit1=g, bit0=dp
//   frame_done  out 1   one-cycle pulse after the thousands slot ends
module seg_scan_arbiter
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 2000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dig_a,
  input  logic [15:0] dig_b,
  input  logic        req_b,
  input  logic        lz_en,
  output logic        gnt_b,
  output logic [3:0]  ctrl,
  output logic [7:0]  segment,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST_CNT  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  slot_state_e   state;
  slot_state_e   state_next;
  owner_e        owner;
  logic [15:0]   snapshot;

  logic          slot_tick;
  logic          frame_tick;
  logic [3:0]    cur_code;
  logic          lz_blank;
  logic [7:0]    dec_seg;
  logic [3:0]    ctrl_d;
  logic [7:0]    seg_d;

  assign slot_tick  = (prescaler == LAST_CNT);
  assign frame_tick = slot_tick && (digit_idx == 2'd3);

  // Owner is itself a register, so the grant only moves on frame ticks.
  assign gnt_b = (owner == OWN_B);

  // Scan timing, arbitration and frame snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      digit_idx  <= 2'd0;
      state      <= ST_BLANK;
      owner      <= OWN_A;
      snapshot   <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= slot_tick ? '0 : prescaler + PW'(1);
      state      <= state_next;
      frame_done <= frame_tick;
      if (slot_tick) begin
        digit_idx <= digit_idx + 2'd1;
      end
      // Owner and snapshot change together so a whole frame comes from one source.
      if (frame_tick) begin
        if (req_b) begin
          owner    <= OWN_B;
          snapshot <= dig_b;
        end else begin
          owner    <= OWN_A;
          snapshot <= dig_a;
        end
      end
    end
  end

  always_comb begin
    cur_code = snapshot[3:0];
    case (digit_idx)
      2'd0: cur_code = snapshot[3:0];
      2'd1: cur_code = snapshot[7:4];
      2'd2: cur_code = snapshot[11:8];
      2'd3: cur_code = snapshot[15:12];
      default: cur_code = snapshot[3:0];
    endcase
  end

  // A digit is a leading zero when it and everything above it are code 0;
  // codes 10-15 are non-zero. Units is never suppressed.
  always_comb begin
    lz_blank = 1'b0;
    if (lz_en) begin
      case (digit_idx)
        2'd3: lz_blank = (snapshot[15:12] == 4'h0);
        2'd2: lz_blank = (snapshot[15:8] == 8'h00);
        2'd1: lz_blank = (snapshot[15:4] == 12'h000);
        default: lz_blank = 1'b0;
      endcase
    end
  end

  seg_decoder u_decoder (
    .code    (cur_code),
    .blank   (lz_blank),
    .segment (dec_seg)
  );

  // Slot FSM next state plus the values the output registers load.
  always_comb begin
    state_next = state;
    ctrl_d     = CTRL_OFF;
    seg_d      = SEG_BLANK;
    case (state)
      ST_BLANK: begin
        if (prescaler == BLANK_END) begin
          state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        ctrl_d = CTRL_TAB[digit_idx];
        seg_d  = dec_seg;
        if (slot_tick) begin
          state_next = ST_BLANK;
        end
      end
      default: state_next = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= CTRL_OFF;
      segment <= SEG_BLANK;
    end else begin
      ctrl    <= ctrl_d;
      segment <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb/tb_seg_scan_arbiter.sv - directed frame-by-frame bench for seg_scan_arbiter
module tb_seg_scan_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dig_a;
  logic [15:0] dig_b;
  logic        req_b;
  logic        lz_en;
  logic        gnt_b;
  logic [3:0]  ctrl;
  logic [7:0]  segment;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_arbiter #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dig_a      (dig_a),
    .dig_b      (dig_b),
    .req_b      (req_b),
    .lz_en      (lz_en),
    .gnt_b      (gnt_b),
    .ctrl       (ctrl),
    .segment    (segment),
    .frame_done (frame_done)
  );

  // One record per frame window. Inputs are applied at the window start;
  // expected segments are what that window shows (the snapshot taken at
  // the previous boundary), gcur/gnext the grant before/after its boundary.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        req;
    logic        lz;
    logic [7:0]  s0, s1, s2, s3;
    logic        gcur, gnext;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] ctab[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts in the cycle with prescaler==1 of a units slot. Each slot shows
  // two dark cycles then six lit ones; the last cycle of the window is the
  // frame_done pulse and carries the new grant.
  task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic gcur, input logic gnext,
                             input int chg_at, input logic chg_req,
                             input int ncyc, input string tag);
    logic [7:0] segs[4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int i = 0; i < ncyc; i++) begin
      int s;
      int o;
      s = i / 8;
      o = i % 8;
      chk({tag, ".ctrl"}, {28'h0, ctrl}, (o < 2) ? 32'hF : {28'h0, ctab[s]});
      chk({tag, ".seg"}, {24'h0, segment}, (o < 2) ? 32'h0 : {24'h0, segs[s]});
      chk({tag, ".gnt"}, {31'h0, gnt_b}, (i == 31) ? {31'h0, gnext} : {31'h0, gcur});
      chk({tag, ".fd"}, {31'h0, frame_done}, (i == 31) ? 32'h1 : 32'h0);
      if (i == chg_at) req_b = chg_req;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ctab[0] = 4'b0111; ctab[1] = 4'b1011; ctab[2] = 4'b1101; ctab[3] = 4'b1110;

    //             a         b         req   lz    units  tens   hund   thou   gcur  gnext
    vecs[0]  = '{16'h1234, 16'h0000, 1'b0, 1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 1'b0, 1'b0};
    vecs[1]  = '{16'h1234, 16'h0000, 1'b0, 1'b0, 8'h66, 8'hF2, 8'hDA, 8'h60, 1'b0, 1'b0};
    vecs[2]  = '{16'h0050, 16'h0000, 1'b0, 1'b1, 8'h66, 8'hF2, 8'hDA, 8'h60, 1'b0, 1'b0};
    vecs[3]  = '{16'h0050, 16'h0000, 1'b0, 1'b1, 8'hFC, 8'hB6, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 8'hFC, 8'hB6, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16'hA00C, 16'h0000, 1'b0, 1'b1, 8'hFC, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{16'hA00C, 16'h0000, 1'b0, 1'b1, 8'h02, 8'hFC, 8'hFC, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{16'hA00C, 16'h0000, 1'b0, 1'b0, 8'h02, 8'hFC, 8'hFC, 8'h02, 1'b0, 1'b0};
    vecs[8]  = '{16'h1234, 16'h0009, 1'b1, 1'b0, 8'h02, 8'hFC, 8'hFC, 8'h02, 1'b0, 1'b1};
    vecs[9]  = '{16'h1234, 16'h0009, 1'b1, 1'b0, 8'hF6, 8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1};
    vecs[10] = '{16'h1234, 16'h0009, 1'b0, 1'b0, 8'hF6, 8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b0};
    vecs[11] = '{16'h1234, 16'h0009, 1'b0, 1'b0, 8'h66, 8'hF2, 8'hDA, 8'h60, 1'b0, 1'b0};

    reset = 1'b1;
    dig_a = 16'h0000;
    dig_b = 16'h0000;
    req_b = 1'b0;
    lz_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ctrl", {28'h0, ctrl}, 32'hF);
    chk("rst.seg", {24'h0, segment}, 32'h0);
    chk("rst.gnt", {31'h0, gnt_b}, 32'h0);
    chk("rst.fd", {31'h0, frame_done}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++) begin
      dig_a = vecs[v].a;
      dig_b = vecs[v].b;
      req_b = vecs[v].req;
      lz_en = vecs[v].lz;
      check_frame(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3,
                  vecs[v].gcur, vecs[v].gnext, -1, 1'b0, 32, $sformatf("vec%0d", v));
    end

    // req_b rises mid-hundreds: grant waits for the boundary.
    dig_a = 16'h1234;
    dig_b = 16'h0009;
    req_b = 1'b0;
    check_frame(8'h66, 8'hF2, 8'hDA, 8'h60, 1'b0, 1'b1, 20, 1'b1, 32, "req_rise");
    // req_b falls during B's tens slot: B holds to the end of the frame.
    check_frame(8'hF6, 8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b0, 12, 1'b0, 32, "req_fall");
    req_b = 1'b1;
    check_frame(8'h66, 8'hF2, 8'hDA, 8'h60, 1'b0, 1'b1, -1, 1'b0, 32, "regrant");
    // Reset in the middle of B's hundreds SHOW slot.
    check_frame(8'hF6, 8'hFC, 8'hFC, 8'hFC, 1'b1, 1'b1, -1, 1'b0, 20, "pre_rst");
    req_b = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.ctrl", {28'h0, ctrl}, 32'hF);
    chk("midrst.seg", {24'h0, segment}, 32'h0);
    chk("midrst.gnt", {31'h0, gnt_b}, 32'h0);
    chk("midrst.fd", {31'h0, frame_done}, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_frame(8'hFC, 8'hFC, 8'hFC, 8'hFC, 1'b0, 1'b0, -1, 1'b0, 32, "post_rst");
    check_frame(8'h66, 8'hF2, 8'hDA, 8'h60, 1'b0, 1'b0, -1, 1'b0, 32, "post_rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
